// File: rtl/wta_spike_decoder_if.sv
// rtl/wta_spike_decoder_if.sv - result handshake bundle for the winner-take-all spike decoder
interface wta_spike_decoder_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] winner_count;
  logic             tie;
  logic             no_spike;

  modport master (
    output out_valid,
    output winner,
    output winner_count,
    output tie,
    output no_spike,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  winner,
    input  winner_count,
    input  tie,
    input  no_spike,
    output out_ready
  );
endinterface

// File: rtl/wta_spike_decoder.sv
// rtl/wta_spike_decoder.sv - windowed per-channel spike counter with sequential winner arbitration
// Optional: WTA_DEC_AUTO_RESTART_EN re-arms the window after each accepted result.
module wta_spike_decoder #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   spike_in,
  input  logic [WIN_W-1:0]    window_len,
  input  logic                start,
  output logic                busy,
  wta_spike_decoder_if.master res
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, COUNT, ARBITRATE, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [WIN_W:0]   win_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             best_tie;
  logic [IDX_W-1:0] nb_idx;
  logic [CNT_W-1:0] nb_cnt;
  logic             nb_tie;
  logic [CNT_W-1:0] cur_cnt;
`ifdef WTA_DEC_AUTO_RESTART_EN
  logic [WIN_W-1:0] win_len_q;
`endif

  // A zero length selects the full 2^WIN_W window, hence the extra counter bit.
  function automatic logic [WIN_W:0] eff_window(input logic [WIN_W-1:0] len);
    eff_window = (len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, len};
  endfunction

  // Running best after folding in the channel currently being scanned.
  always_comb begin
    cur_cnt = cnt[scan_idx];
    nb_idx  = best_idx;
    nb_cnt  = best_cnt;
    nb_tie  = best_tie;
    if (scan_idx == '0) begin
      nb_idx = '0;
      nb_cnt = cur_cnt;
      nb_tie = 1'b0;
    end else if (cur_cnt > best_cnt) begin
      nb_idx = scan_idx;
      nb_cnt = cur_cnt;
      nb_tie = 1'b0;
    end else if (cur_cnt == best_cnt) begin
      nb_tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      win_cnt          <= '0;
      scan_idx         <= '0;
      best_idx         <= '0;
      best_cnt         <= '0;
      best_tie         <= 1'b0;
      res.out_valid    <= 1'b0;
      res.winner       <= '0;
      res.winner_count <= '0;
      res.tie          <= 1'b0;
      res.no_spike     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
`ifdef WTA_DEC_AUTO_RESTART_EN
      win_len_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            win_cnt <= eff_window(window_len);
            busy    <= 1'b1;
            state   <= COUNT;
`ifdef WTA_DEC_AUTO_RESTART_EN
            win_len_q <= window_len;
`endif
          end
        end
        COUNT: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (spike_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
          end
          win_cnt <= win_cnt - (WIN_W+1)'(1);
          if (win_cnt == (WIN_W+1)'(1)) begin
            scan_idx <= '0;
            state    <= ARBITRATE;
          end
        end
        ARBITRATE: begin
          best_idx <= nb_idx;
          best_cnt <= nb_cnt;
          best_tie <= nb_tie;
          scan_idx <= scan_idx + IDX_W'(1);
          if (scan_idx == LAST_IDX) begin
            res.winner       <= nb_idx;
            res.winner_count <= nb_cnt;
            res.tie          <= nb_tie;
            res.no_spike     <= (nb_cnt == '0);
            res.out_valid    <= 1'b1;
            state            <= HOLD;
          end
        end
        HOLD: begin
          if (res.out_ready) begin
            res.out_valid <= 1'b0;
`ifdef WTA_DEC_AUTO_RESTART_EN
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            win_cnt <= eff_window(win_len_q);
            state   <= COUNT;
`else
            busy    <= 1'b0;
            state   <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wta_spike_decoder.sv
// tb/tb_wta_spike_decoder.sv - scoreboard bench for wta_spike_decoder
module tb_wta_spike_decoder;
  typedef struct {
    logic [1:0] winner;
    int         count;
    logic       tie;
    logic       no_spike;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] spike_in = '0;
  logic [7:0] window_len = '0;
  logic       start = 1'b0;
  logic       start_s = 1'b0;
  logic       busy;
  logic       busy_s;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  wta_spike_decoder_if #(.NUM_CH(4), .CNT_W(8)) res_if ();
  wta_spike_decoder_if #(.NUM_CH(4), .CNT_W(4)) res_s ();

  wta_spike_decoder #(.NUM_CH(4), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .window_len(window_len),
    .start(start), .busy(busy), .res(res_if)
  );

  wta_spike_decoder #(.NUM_CH(4), .CNT_W(4), .WIN_W(8)) dut_s (
    .clk(clk), .rst(rst), .spike_in(spike_in), .window_len(window_len),
    .start(start_s), .busy(busy_s), .res(res_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_if.out_ready = 1'b1;
    res_s.out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (res_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", res_if.out_valid); end
    checks++; if (res_if.winner !== 2'd0) begin errors++; $display("FAIL reset_winner got=%0d want=0", res_if.winner); end
    checks++; if (res_if.winner_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", res_if.winner_count); end
    checks++; if (res_if.tie !== 1'b0) begin errors++; $display("FAIL reset_tie got=%b want=0", res_if.tie); end
    checks++; if (res_if.no_spike !== 1'b0) begin errors++; $display("FAIL reset_no_spike got=%b want=0", res_if.no_spike); end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int k = 0; k < 10; k++) begin
      spike_in = 4'($urandom);
      tick();
      if (busy !== 1'b0 || res_if.out_valid !== 1'b0 || res_if.winner_count !== 8'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_no_change got=%0d bad cycles want=0", bad); end
  endtask

  // One full window on the main DUT; mode 1 drives random spikes instead of pat.
  task automatic run_window(input int wlen, input bit rnd, input logic [3:0] pat,
                            input int hold_cycles, input bit poke);
    int   w;
    int   c [4];
    int   cyc;
    exp_t e;
    exp_t got;
    w = (wlen == 0) ? 256 : wlen;
    for (int i = 0; i < 4; i++) c[i] = 0;
    res_if.out_ready = (hold_cycles == 0);
    window_len = 8'(wlen);
    start = 1'b1;
    tick();
    for (int k = 1; k <= w; k++) begin
      spike_in = rnd ? 4'($urandom) : pat;
      start = (poke && k == 2);
      for (int i = 0; i < 4; i++) if (spike_in[i] && c[i] < 255) c[i]++;
      tick();
    end
    start = 1'b0;
    spike_in = 4'($urandom);
    e.winner = 2'd0; e.count = c[0]; e.tie = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (c[i] > e.count) begin e.winner = 2'(i); e.count = c[i]; e.tie = 1'b0; end
      else if (c[i] == e.count) e.tie = 1'b1;
    end
    e.no_spike = (e.count == 0);
    exp_q.push_back(e);
    cyc = w + 1;
    while (res_if.out_valid !== 1'b1 && cyc < w + 20) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != w + 5) begin errors++; $display("FAIL latency w=%0d got=%0d want=%0d", w, cyc, w + 5); end
    got = exp_q.pop_front();
    checks++; if (res_if.winner !== got.winner) begin errors++; $display("FAIL winner w=%0d got=%0d want=%0d", w, res_if.winner, got.winner); end
    checks++; if (res_if.winner_count !== 8'(got.count)) begin errors++; $display("FAIL winner_count w=%0d got=%0d want=%0d", w, res_if.winner_count, got.count); end
    checks++; if (res_if.tie !== got.tie) begin errors++; $display("FAIL tie w=%0d got=%b want=%b", w, res_if.tie, got.tie); end
    checks++; if (res_if.no_spike !== got.no_spike) begin errors++; $display("FAIL no_spike w=%0d got=%b want=%b", w, res_if.no_spike, got.no_spike); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_hold got=%b want=1", busy); end
    for (int h = 1; h <= hold_cycles; h++) begin
      start = (h == 2);
      tick();
      checks++;
      if (res_if.out_valid !== 1'b1 || res_if.winner !== got.winner || res_if.winner_count !== 8'(got.count)) begin
        errors++;
        $display("FAIL hold_stable cycle=%0d got valid=%b winner=%0d count=%0d want valid=1 winner=%0d count=%0d",
                 h, res_if.out_valid, res_if.winner, res_if.winner_count, got.winner, got.count);
      end
    end
    start = 1'b0;
    res_if.out_ready = 1'b1;
    tick();
    checks++; if (res_if.out_valid !== 1'b0) begin errors++; $display("FAIL valid_after_handshake got=%b want=0", res_if.out_valid); end
`ifdef WTA_DEC_AUTO_RESTART_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_handshake got=%b want=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_handshake got=%b want=0", busy); end
`endif
  endtask

  task automatic test_single_winner();
    run_window(10, 1'b0, 4'b0100, 0, 1'b0);
  endtask

  task automatic test_tie_and_empty();
    run_window(5, 1'b0, 4'b1010, 0, 1'b0);
    run_window(8, 1'b0, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_random();
    run_window(12, 1'b1, 4'b0000, 0, 1'b0);
    run_window(1, 1'b1, 4'b0000, 0, 1'b0);
    run_window(17, 1'b1, 4'b0000, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_window(6, 1'b0, 4'b0110, 5, 1'b1);
  endtask

  task automatic test_saturation();
    int   cyc;
    exp_t e;
    exp_t got;
    window_len = 8'd0;
    spike_in = 4'b0001;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    e.winner = 2'd0; e.count = 15; e.tie = 1'b0; e.no_spike = 1'b0;
    exp_q.push_back(e);
    cyc = 1;
    while (res_s.out_valid !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 261) begin errors++; $display("FAIL sat_latency got=%0d want=261", cyc); end
    got = exp_q.pop_front();
    checks++; if (res_s.winner_count !== 4'(got.count)) begin errors++; $display("FAIL sat_count got=%0d want=%0d", res_s.winner_count, got.count); end
    checks++; if (res_s.winner !== got.winner || res_s.tie !== got.tie) begin errors++; $display("FAIL sat_winner got=%0d/%b want=%0d/%b", res_s.winner, res_s.tie, got.winner, got.tie); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    int bad = 0;
    window_len = 8'd20;
    spike_in = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (res_if.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_rst_idle got=%0d bad cycles want=0", bad); end
    run_window(3, 1'b0, 4'b0000, 0, 1'b0);
  endtask

`ifdef WTA_DEC_AUTO_RESTART_EN
  task automatic test_auto_restart();
    int   cyc;
    int   busy_drop = 0;
    exp_t e;
    exp_t got;
    res_if.out_ready = 1'b1;
    window_len = 8'd4;
    spike_in = 4'b0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      e.winner = 2'd0; e.count = 4; e.tie = 1'b0; e.no_spike = 1'b0;
      exp_q.push_back(e);
      cyc = 1;
      while (res_if.out_valid !== 1'b1 && cyc < 40) begin
        if (busy !== 1'b1) busy_drop++;
        tick();
        cyc++;
      end
      got = exp_q.pop_front();
      checks++; if (cyc != 9) begin errors++; $display("FAIL restart_period run=%0d got=%0d want=9", r, cyc); end
      checks++; if (res_if.winner !== got.winner || res_if.winner_count !== 8'(got.count)) begin
        errors++; $display("FAIL restart_result run=%0d got=%0d/%0d want=%0d/%0d", r, res_if.winner, res_if.winner_count, got.winner, got.count);
      end
      tick();
    end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL restart_busy got=%0d drops want=0", busy_drop); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
`else
  task automatic test_no_restart();
    int bad = 0;
    run_window(4, 1'b0, 4'b0001, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (res_if.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_restart_idle got=%0d bad cycles want=0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single_winner();
    test_tie_and_empty();
    test_random();
    test_backpressure();
    test_saturation();
    test_reset_mid_count();
`ifdef WTA_DEC_AUTO_RESTART_EN
    test_auto_restart();
`else
    test_no_restart();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
